mcu_request_arbiter: RTL and testbench

Shares the single `iRequest` port of the memory controller between up to `REQUESTERS` independent request sources, such as the host loader, per-core DMA stubs and the scene fetcher. Each source owns a one-deep holding slot with a valid/ack handshake. A round-robin scheduler forwards one copy-block request word at a time into the memory controller's request FIFO, throttled by that FIFO's full flag. Requests with an all-zero VP mask are invisible to the memory controller, so the arbiter discards and counts them.

---
 rtl/mcu_request_arbiter_if.sv | 33 +++
 rtl/mcu_request_arbiter.sv | 135 +++++++++++++
 tb/tb_mcu_request_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_request_arbiter_if.sv
// Request-source and memory-controller signals of the MCU request arbiter.
// Sources and the request FIFO sit on the master side; the arbiter is the slave.
`ifndef MCU_REQUEST_SIZE
`define MCU_REQUEST_SIZE 32
`endif
`ifndef MCU_VPMASK_LEN
`define MCU_VPMASK_LEN 8
`endif

interface mcu_request_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int REQ_WIDTH  = `MCU_REQUEST_SIZE
);
    localparam int IDW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    logic [REQUESTERS-1:0]           iReqValid;
    logic [REQUESTERS*REQ_WIDTH-1:0] iReqData;
    logic [REQUESTERS-1:0]           oReqAck;
    logic [REQ_WIDTH-1:0]            oRequest;
    logic [IDW-1:0]                  oGrantId;
    logic                            iFifoFull;
    logic                            iFifoEmpty;

    modport master (
        output iReqValid, iReqData, iFifoFull, iFifoEmpty,
        input  oReqAck, oRequest, oGrantId
    );

    modport slave (
        input  iReqValid, iReqData, iFifoFull, iFifoEmpty,
        output oReqAck, oRequest, oGrantId
    );
endinterface

// File: rtl/mcu_request_arbiter.sv
// Round-robin arbiter sharing the memory controller request port.
// Each source owns a one-deep slot; zero-mask words are dropped and counted.
`ifndef MCU_REQUEST_SIZE
`define MCU_REQUEST_SIZE 32
`endif
`ifndef MCU_VPMASK_LEN
`define MCU_VPMASK_LEN 8
`endif

module mcu_request_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int REQ_WIDTH  = `MCU_REQUEST_SIZE,
    parameter int MASK_LSB   = 0,
    parameter int MASK_WIDTH = `MCU_VPMASK_LEN
) (
    input  logic                    Clock,
    input  logic                    Reset,
    mcu_request_arbiter_if.slave    bus,
    output logic [REQUESTERS-1:0]   oPendingMask,
    output logic                    oBusy,
    output logic [7:0]              oDropCount
);
    localparam int IDW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic {IDLE, GAP} state_t;

    state_t                               state;
    state_t                               stateNext;
    logic [REQUESTERS-1:0]                slotFull;
    logic [REQUESTERS-1:0][REQ_WIDTH-1:0] slotData;
    logic [REQUESTERS-1:0]                ackQ;
    logic [REQUESTERS-1:0]                take;
    logic [REQUESTERS-1:0]                keep;
    logic [REQUESTERS-1:0]                drop;
    logic [REQ_WIDTH-1:0]                 reqQ;
    logic [IDW-1:0]                       gidQ;
    logic [IDW-1:0]                       rr;
    logic [IDW-1:0]                       winner;
    logic                                 found;
    logic                                 issue;
    logic [8:0]                           dropSum;
    int                                   idx;

    // Ack-low qualifier stops a stale word being captured twice.
    always_comb begin
        take = '0;
        keep = '0;
        drop = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            take[i] = bus.iReqValid[i] & ~slotFull[i] & ~ackQ[i];
            keep[i] = take[i] &
                (|bus.iReqData[i*REQ_WIDTH+MASK_LSB +: MASK_WIDTH]);
            drop[i] = take[i] & ~keep[i];
        end
    end

    always_comb begin
        dropSum = {1'b0, oDropCount};
        for (int i = 0; i < REQUESTERS; i++) begin
            dropSum = dropSum + 9'(drop[i]);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = (int'(rr) + k) % REQUESTERS;
            if (!found && slotFull[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !bus.iFifoFull) begin
                    issue     = 1'b1;
                    stateNext = GAP;
                end
            end
            GAP: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            slotFull   <= '0;
            slotData   <= '0;
            ackQ       <= '0;
            reqQ       <= '0;
            gidQ       <= '0;
            rr         <= '0;
            oDropCount <= '0;
        end else begin
            ackQ       <= take;
            oDropCount <= (dropSum > 9'd255) ? 8'hFF : dropSum[7:0];
            reqQ       <= issue ? slotData[winner] : '0;
            if (issue) begin
                gidQ <= winner;
                rr   <= (winner == IDW'(REQUESTERS-1)) ?
                        '0 : winner + IDW'(1);
            end
            // A slot being issued is full, so it never captures this edge.
            for (int i = 0; i < REQUESTERS; i++) begin
                if (keep[i]) begin
                    slotFull[i] <= 1'b1;
                    slotData[i] <= bus.iReqData[i*REQ_WIDTH +: REQ_WIDTH];
                end else if (issue && winner == IDW'(i)) begin
                    slotFull[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.oReqAck  = ackQ;
    assign bus.oRequest = reqQ;
    assign bus.oGrantId = gidQ;
    assign oPendingMask = slotFull;
    assign oBusy        = (|slotFull) | (state != IDLE) | ~bus.iFifoEmpty;

endmodule

// File: tb/tb_mcu_request_arbiter.sv
// Bench for mcu_request_arbiter: directed scenarios, then random traffic,
// each cycle compared with a slot/turn-level reference model.
`timescale 1ns/1ps
module tb_mcu_request_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [N-1:0] oPendingMask;
    logic         oBusy;
    logic [7:0]   oDropCount;

    mcu_request_arbiter_if #(.REQUESTERS(N), .REQ_WIDTH(W)) bus();

    mcu_request_arbiter #(
        .REQUESTERS(N), .REQ_WIDTH(W), .MASK_LSB(0), .MASK_WIDTH(8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus.slave),
        .oPendingMask(oPendingMask),
        .oBusy(oBusy),
        .oDropCount(oDropCount)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: pending words per source, turn pointer,
    // and a one-cycle spacing after every issue.
    bit           mFull[N];
    logic [W-1:0] mWord[N];
    bit           mAck[N];
    int           mRr;
    int           mDrop;
    int           mCool;
    logic [W-1:0] mReq;
    int           mGid;
    int           seq;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic setSrc(int i, bit v, logic [W-1:0] d);
        bus.iReqValid[i]       = v;
        bus.iReqData[i*W +: W] = d;
    endtask

    function automatic logic [W-1:0] mkWord(int s);
        return (W'(s) << 16) | W'((s % 255) + 1);
    endfunction

    function automatic logic [W-1:0] rndWord();
        logic [W-1:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[7:0] = 8'h00;
        return w;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mFull[i] = 0;
            mWord[i] = '0;
            mAck[i]  = 0;
        end
        mRr   = 0;
        mDrop = 0;
        mCool = 0;
        mReq  = '0;
        mGid  = 0;
    endtask

    task automatic modelStep();
        bit           nf[N];
        bit           na[N];
        bit           any;
        int           w;
        logic [W-1:0] d;
        nf  = mFull;
        any = 0;
        w   = 0;
        if (mCool == 0 && !bus.iFifoFull) begin
            for (int k = 0; k < N; k++) begin
                if (!any && mFull[(mRr + k) % N]) begin
                    any = 1;
                    w   = (mRr + k) % N;
                end
            end
        end
        if (any) begin
            mReq  = mWord[w];
            mGid  = w;
            nf[w] = 0;
            mRr   = (w + 1) % N;
            mCool = 1;
        end else begin
            mReq  = '0;
            mCool = 0;
        end
        for (int i = 0; i < N; i++) begin
            d     = bus.iReqData[i*W +: W];
            na[i] = 0;
            if (bus.iReqValid[i] && !mFull[i] && !mAck[i]) begin
                na[i] = 1;
                if (d[7:0] != 8'h00) begin
                    nf[i]    = 1;
                    mWord[i] = d;
                end else if (mDrop < 255) begin
                    mDrop++;
                end
            end
        end
        mFull = nf;
        mAck  = na;
    endtask

    task automatic checkAll(string tag);
        logic [N-1:0] ea;
        logic [N-1:0] ep;
        bit           eb;
        for (int i = 0; i < N; i++) begin
            ea[i] = mAck[i];
            ep[i] = mFull[i];
        end
        eb = (|ep) || (mCool != 0) || !bus.iFifoEmpty;
        chk({tag, "/ack"}, bus.oReqAck, ea);
        chk({tag, "/req"}, bus.oRequest, mReq);
        chk({tag, "/gid"}, bus.oGrantId, mGid);
        chk({tag, "/pend"}, oPendingMask, ep);
        chk({tag, "/drop"}, oDropCount, mDrop);
        chk({tag, "/busy"}, oBusy, eb);
    endtask

    task automatic tick(string tag);
        if (Reset) modelStep();
        else modelReset();
        @(posedge Clock);
        #1;
        checkAll(tag);
    endtask

    initial begin
        int lastGid;
        int cnt;
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] wc;

        bus.iReqValid  = '0;
        bus.iReqData   = '0;
        bus.iFifoFull  = 1'b0;
        bus.iFifoEmpty = 1'b1;
        Reset          = 1'b0;
        seq            = 1;
        modelReset();

        // Reset state
        tick("reset");
        tick("reset");
        bus.iFifoEmpty = 1'b0;
        #1 chk("reset_busy_fifo", oBusy, 1);
        bus.iFifoEmpty = 1'b1;
        #1 chk("reset_busy_idle", oBusy, 0);
        Reset = 1'b1;

        // Single request from source 2
        setSrc(2, 1, 32'h0000_1001);
        tick("single");
        chk("single_ack", bus.oReqAck, 4'b0100);
        setSrc(2, 0, '0);
        tick("single");
        chk("single_req", bus.oRequest, 32'h0000_1001);
        chk("single_gid", bus.oGrantId, 2);
        tick("single");
        chk("single_gap", bus.oRequest, 0);
        repeat (2) tick("single_tail");

        // Round-robin fairness, pointer sits at 3 after source 2
        for (int i = 0; i < N; i++) begin
            setSrc(i, 1, mkWord(seq));
            seq++;
        end
        lastGid = 2;
        cnt     = 0;
        repeat (40) begin
            tick("rr");
            if (bus.oRequest != '0) begin
                chk("rr_order", bus.oGrantId, (lastGid + 1) % N);
                lastGid = int'(bus.oGrantId);
                cnt++;
            end
            for (int i = 0; i < N; i++) begin
                if (mAck[i]) begin
                    setSrc(i, 1, mkWord(seq));
                    seq++;
                end
            end
        end
        chk("rr_rate", cnt, 20);
        bus.iReqValid = '0;
        repeat (12) tick("rr_drain");

        // Backpressure with three slots full
        bus.iFifoFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setSrc(i, 1, mkWord(seq));
            seq++;
        end
        tick("bp_cap");
        for (int i = 0; i < 3; i++) begin
            setSrc(i, 1, mkWord(seq));
            seq++;
        end
        repeat (20) begin
            tick("bp_hold");
            chk("bp_req", bus.oRequest, 0);
            chk("bp_pend", oPendingMask, 4'b0111);
            chk("bp_noack", bus.oReqAck, 0);
        end
        bus.iFifoFull = 1'b0;
        repeat (20) begin
            tick("bp_resume");
            for (int i = 0; i < N; i++) begin
                if (mAck[i]) setSrc(i, 0, '0);
            end
        end
        bus.iReqValid = '0;
        repeat (4) tick("bp_tail");

        // Zero-mask drops on source 1
        chk("drop_start", oDropCount, 0);
        cnt = 0;
        setSrc(1, 1, 32'h0000_AB00);
        repeat (6) begin
            tick("drop");
            chk("drop_noissue", bus.oRequest, 0);
            if (mAck[1]) begin
                cnt++;
                setSrc(1, cnt < 3, W'(cnt) << 8);
            end
        end
        chk("drop_acks", cnt, 3);
        chk("drop_three", oDropCount, 3);
        setSrc(1, 1, 32'h0001_0000);
        repeat (620) begin
            tick("drop_sat");
            if (mAck[1]) begin
                cnt++;
                setSrc(1, cnt < 303, W'(cnt) << 8);
            end
        end
        chk("drop_sat", oDropCount, 255);
        bus.iReqValid = '0;

        // Simultaneous capture and issue, pointer at 0 after reset
        Reset = 1'b0;
        #1 modelReset();
        tick("sim_rst");
        Reset = 1'b1;
        wa = 32'hA000_0011;
        wb = 32'hB000_0022;
        wc = 32'hC000_0033;
        setSrc(0, 1, wa);
        tick("sim");
        chk("sim_ackA", bus.oReqAck, 4'b0001);
        setSrc(0, 1, wb);
        setSrc(3, 1, wc);
        tick("sim");
        chk("sim_issueA", bus.oRequest, wa);
        chk("sim_ackC", bus.oReqAck, 4'b1000);
        setSrc(3, 0, '0);
        tick("sim");
        chk("sim_ackB", bus.oReqAck, 4'b0001);
        setSrc(0, 0, '0);
        tick("sim");
        chk("sim_issueC", bus.oRequest, wc);
        chk("sim_gidC", bus.oGrantId, 3);
        tick("sim");
        tick("sim");
        chk("sim_issueB", bus.oRequest, wb);
        chk("sim_gidB", bus.oGrantId, 0);
        repeat (4) tick("sim_tail");

        // Reset during a gap cycle with two slots full
        for (int i = 1; i < 4; i++) begin
            setSrc(i, 1, mkWord(seq));
            seq++;
        end
        tick("mid_cap");
        bus.iReqValid = '0;
        tick("mid_issue");
        chk("mid_pend2", oPendingMask, 4'b1100);
        #1 Reset = 1'b0;
        #1 modelReset();
        checkAll("mid_async");
        chk("mid_req0", bus.oRequest, 0);
        tick("mid_hold");
        Reset = 1'b1;
        repeat (8) begin
            tick("mid_quiet");
            chk("mid_noissue", bus.oRequest, 0);
        end
        setSrc(1, 1, mkWord(seq));
        setSrc(0, 1, mkWord(seq + 1));
        seq += 2;
        tick("mid_new");
        bus.iReqValid = '0;
        tick("mid_new");
        chk("mid_rr0", bus.oGrantId, 0);
        repeat (4) tick("mid_tail");

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.iFifoFull  = ($urandom_range(0, 9) < 3);
            bus.iFifoEmpty = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if (mAck[i] || !bus.iReqValid[i]) begin
                    if ($urandom_range(0, 2) != 0) setSrc(i, 1, rndWord());
                    else setSrc(i, 0, '0);
                end
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
